// File: rtl/wb_mem_slave_if.sv
// Wishbone-style bus bundle between a master (e.g. ctrl_unit) and wb_mem_slave.
// The master drives the request fields and the slave returns the completion fields.
interface wb_mem_slave_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
);
  logic [ADDR_SIZE-1:0] Wb_addr;
  logic                 Wb_cs;
  logic                 Wb_we;
  logic [WORD_SIZE-1:0] Wb_wdata;
  logic [WORD_SIZE-1:0] Wb_rdata;
  logic                 Wb_ack;
  logic                 Wb_err;

  modport master (
    output Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    input  Wb_rdata, Wb_ack, Wb_err
  );

  modport slave (
    input  Wb_addr, Wb_cs, Wb_we, Wb_wdata,
    output Wb_rdata, Wb_ack, Wb_err
  );
endinterface

// File: rtl/wb_mem_slave.sv
// Single-port word memory serving instruction fetch and LW/SW over a Wishbone-style bus.
// Programmable wait states, one-cycle registered ack, error flag for out-of-range addresses.
module wb_mem_slave #(
  parameter int ADDR_SIZE   = 32,
  parameter int WORD_SIZE   = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input logic           Clk,
  input logic           Rst_n,
  wb_mem_slave_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 oor_q, oor_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic                 mem_we;

  logic [AW-1:0]        req_idx;
  logic                 req_oor;
  logic                 enter_ack;
  logic [AW-1:0]        ack_idx;
  logic                 ack_oor;
  logic                 ack_we;

  // Byte offset is ignored: all accesses are word-aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.Wb_addr[1:0];

  assign req_idx = bus.Wb_addr[AW+1:2];
  assign req_oor = |bus.Wb_addr[ADDR_SIZE-1:AW+2];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    oor_d     = oor_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    mem_we    = 1'b0;
    enter_ack = 1'b0;
    ack_idx   = idx_q;
    ack_oor   = oor_q;
    ack_we    = we_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Wb_cs) begin
          idx_d   = req_idx;
          oor_d   = req_oor;
          we_d    = bus.Wb_we;
          wdata_d = bus.Wb_wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_STATES == 0) begin
            // Zero wait states: ack uses the request being captured on this same edge.
            state_d   = ST_ACK;
            enter_ack = 1'b1;
            ack_idx   = req_idx;
            ack_oor   = req_oor;
            ack_we    = bus.Wb_we;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (!bus.Wb_cs) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end

      ST_ACK: begin
        // The write lands on the edge leaving ST_ACK, so a master that drops cs cancels it.
        mem_we  = we_q && !oor_q && bus.Wb_cs;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (enter_ack) begin
      ack_d = 1'b1;
      err_d = ack_oor;
      if (!ack_we && !ack_oor) begin
        rdata_d = mem_q[ack_idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array has no reset; contents survive Rst_n and it still maps onto RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign bus.Wb_ack   = ack_q;
  assign bus.Wb_err   = err_q;
  assign bus.Wb_rdata = rdata_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench for wb_mem_slave: scoreboarded accesses, latency, abort, range errors and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_wb_mem_slave;

  localparam int W     = 2;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_mem_slave_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus ();

  wb_mem_slave #(
    .ADDR_SIZE  (32),
    .WORD_SIZE  (32),
    .DEPTH      (DEPTH),
    .WAIT_STATES(W)
  ) dut (
    .Clk  (clk),
    .Rst_n(rst_n),
    .bus  (bus)
  );

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access starting on a falling edge; returns on the falling edge of the idle cycle.
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic keep_cs);
    exp_t        e;
    int          n;
    logic        seen;
    logic        oor;
    logic [31:0] a;
    a       = addr;
    oor     = (a >= 32'(DEPTH * 4));
    e.err   = oor;
    e.rdata = (we || oor) ? 32'h0 : model[a[11:2]];
    sb.push_back(e);
    if (we && !oor) model[a[11:2]] = wdata;

    bus.Wb_cs    = 1'b1;
    bus.Wb_we    = we;
    bus.Wb_addr  = addr;
    bus.Wb_wdata = wdata;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.Wb_addr  = ~addr;
        bus.Wb_wdata = ~wdata;
      end
      if (bus.Wb_ack === 1'b1) seen = 1'b1;
    end
    check({name, ".ack_seen"}, 32'(seen), 32'd1);
    check({name, ".latency"}, 32'(n), 32'(W + 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({name, ".rdata"}, bus.Wb_rdata, e.rdata);
      check({name, ".err"}, 32'(bus.Wb_err), 32'(e.err));
    end
    @(negedge clk);
    check({name, ".ack_width"}, 32'(bus.Wb_ack), 32'd0);
    if (!keep_cs) bus.Wb_cs = 1'b0;
  endtask

  initial begin
    bus.Wb_cs    = 1'b0;
    bus.Wb_we    = 1'b0;
    bus.Wb_addr  = '0;
    bus.Wb_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst.ack", 32'(bus.Wb_ack), 32'd0);
    check("rst.err", 32'(bus.Wb_err), 32'd0);
    check("rst.rdata", bus.Wb_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.ack", 32'(bus.Wb_ack), 32'd0);

    // Preload through the bus
    access("pre0c", 1'b1, 32'h0000_000C, 32'h00A0_0093, 1'b0);
    access("pre10", 1'b1, 32'h0000_0010, 32'h1111_1111, 1'b0);
    access("pre20", 1'b1, 32'h0000_0020, 32'h2222_2222, 1'b0);
    access("pre00", 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0);
    access("pre04", 1'b1, 32'h0000_0004, 32'h5A5A_5A5A, 1'b0);
    access("preffc", 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);

    // Read latency and data
    access("t2_rd0c", 1'b0, 32'h0000_000C, 32'h0, 1'b0);

    // Write then read with cs held through the idle cycle
    access("t3_wr40", 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1);
    access("t3_rd40", 1'b0, 32'h0000_0040, 32'h0, 1'b0);

    // Abort a write during the wait phase
    bus.Wb_cs    = 1'b1;
    bus.Wb_we    = 1'b1;
    bus.Wb_addr  = 32'h0000_0020;
    bus.Wb_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.Wb_cs = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_no_ack", 32'(bus.Wb_ack), 32'd0);
    end
    access("t4_rd20", 1'b0, 32'h0000_0020, 32'h0, 1'b0);

    // Out-of-range accesses alias onto words 0/1 if decoded wrongly
    access("t5_rd1000", 1'b0, 32'h0000_1000, 32'h0, 1'b0);
    access("t5_wr1004", 1'b1, 32'h0000_1004, 32'hBAD0_BAD0, 1'b0);
    access("t5_rd00", 1'b0, 32'h0000_0000, 32'h0, 1'b0);
    access("t5_rd04", 1'b0, 32'h0000_0004, 32'h0, 1'b0);
    access("t5_rdffc", 1'b0, 32'h0000_0FFC, 32'h0, 1'b0);

    // Reset during the ack cycle forces the outputs low immediately
    bus.Wb_cs   = 1'b1;
    bus.Wb_we   = 1'b0;
    bus.Wb_addr = 32'h0000_0FFC;
    repeat (W + 1) @(negedge clk);
    check("rstack.pre_ack", 32'(bus.Wb_ack), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstack.ack", 32'(bus.Wb_ack), 32'd0);
    check("rstack.rdata", bus.Wb_rdata, 32'd0);
    bus.Wb_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a pending write drops it
    bus.Wb_cs    = 1'b1;
    bus.Wb_we    = 1'b1;
    bus.Wb_addr  = 32'h0000_0010;
    bus.Wb_wdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1.ack", 32'(bus.Wb_ack), 32'd0);
    bus.Wb_cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t1.quiet", 32'(bus.Wb_ack), 32'd0);
    access("t1_rd10", 1'b0, 32'h0000_0010, 32'h0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
